// File: rtl/mux_2_4.sv
// Purpose: 8-bit 4:1 operand-steering mux (S selects in0..in3), with optional registered copy.
// Latency: out is combinational (0 cycles); out_q/sel_q/chg are 1 cycle when MUX_2_4_REG_OUT_EN is defined.
// Backpressure: none; the selected source is always presented, no handshake is involved.
//
// Build option: define MUX_2_4_REG_OUT_EN to build the out_q/sel_q/chg flip-flops.
// Without it, out_q mirrors out, sel_q mirrors S and chg is tied low; clk/rst are then unused.

module mux_2_4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q,
  output logic             chg
);

  // Full decode of the select code; an unknown select drives all-x rather than
  // falling back to any source, so a bad select is visible downstream in simulation.
  always_comb begin
    case (S)
      2'b00:   out = in0;
      2'b01:   out = in1;
      2'b10:   out = in2;
      2'b11:   out = in3;
      default: out = {WIDTH{1'bx}};
    endcase
  end

`ifdef MUX_2_4_REG_OUT_EN

  logic [WIDTH-1:0] out_d;
  logic [1:0]       sel_d;
  logic             chg_d;
  logic             chg_q;

  // Next-state: capture the current selection and flag a select that differs
  // from the one captured at the previous edge.
  always_comb begin
    out_d = out;
    sel_d = S;
    chg_d = (S != sel_q);
  end

  // Registered copy; reset clears everything immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      sel_q <= 2'b00;
      chg_q <= 1'b0;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
      chg_q <= chg_d;
    end
  end

  assign chg = chg_q;

`else

  // Pass-through build: registered outputs collapse onto the combinational path.
  assign out_q = out;
  assign sel_q = S;
  assign chg   = 1'b0;

  // clk and rst stay on the port list for drop-in compatibility but drive nothing here.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

`endif

endmodule

// File: tb/tb_mux_2_4.sv
// Directed bench for mux_2_4: combinational select sweep, isolation of unselected
// inputs, registered path (reset, change pulse, one-cycle tracking) and unknown select.
// Expectations for out_q/sel_q/chg follow whichever build option is compiled.

module tb_mux_2_4;

  logic       clk;
  logic       rst;
  logic [1:0] s;
  logic [7:0] in0, in1, in2, in3;
  logic [7:0] out, out_q;
  logic [1:0] sel_q;
  logic       chg;
  logic       clk_en;

  int vectors;
  int miscompares;

  mux_2_4 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .S     (s),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .out   (out),
    .out_q (out_q),
    .sel_q (sel_q),
    .chg   (chg)
  );

  // Gated clock so the combinational checks run with no edges at all.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Hard stop if anything stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] pick(input logic [1:0] sel, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c,
                                      input logic [7:0] d);
    case (sel)
      2'b00:   pick = a;
      2'b01:   pick = b;
      2'b10:   pick = c;
      2'b11:   pick = d;
      default: pick = 8'hxx;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Registered-path check: with the flops built, compare against the given
  // one-cycle-late values; otherwise the outputs must mirror the live path.
  task automatic chk_regs(input string tag, input logic [7:0] e_oq,
                          input logic [1:0] e_sq, input logic e_chg);
`ifdef MUX_2_4_REG_OUT_EN
    chk({tag, ".out_q"}, out_q, e_oq);
    chk({tag, ".sel_q"}, {6'd0, sel_q}, {6'd0, e_sq});
    chk({tag, ".chg"},   {7'd0, chg},   {7'd0, e_chg});
`else
    chk({tag, ".out_q"}, out_q, pick(s, in0, in1, in2, in3));
    chk({tag, ".sel_q"}, {6'd0, sel_q}, {6'd0, s});
    chk({tag, ".chg"},   {7'd0, chg},   8'd0);
    if (e_chg === 1'bz) chk({tag, ".unreach"}, e_oq, {6'd0, e_sq});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk_en      = 1'b0;
    rst         = 1'b1;
    s           = 2'b00;
    in0 = 8'hFF; in1 = 8'h00; in2 = 8'h01; in3 = 8'hFE;

    // Combinational select with no clock, reset held.
    #10;
    chk("sel00", out, 8'hFF);
    chk_regs("reset", 8'h00, 2'b00, 1'b0);

    s = 2'b01; #10; chk("sel01", out, 8'h00);
    s = 2'b10; #10; chk("sel10", out, 8'h01);
    s = 2'b11; #10; chk("sel11", out, 8'hFE);

    // Unselected inputs must not disturb out; the selected one passes through.
    in0 = 8'h5A; in1 = 8'hA5; in2 = 8'h3C; #1;
    chk("unsel_toggle", out, 8'hFE);
    in3 = 8'h5A; #1;
    chk("sel_toggle", out, 8'h5A);
    in3 = 8'hFE; #1;
    chk("sel_restore", out, 8'hFE);
    in0 = 8'hFF; in1 = 8'h00; in2 = 8'h01;

    // Leave reset with S=00, start clocking.
    s = 2'b00; #2;
    rst = 1'b0;
    clk_en = 1'b1;
    tick();
    chk_regs("first_edge_s00", 8'hFF, 2'b00, 1'b0);

    // 00 -> 11 -> 11 -> 01 on consecutive edges.
    s = 2'b11; tick();
    chk_regs("seq_11a", 8'hFE, 2'b11, 1'b1);
    tick();
    chk_regs("seq_11b", 8'hFE, 2'b11, 1'b0);
    in1 = 8'h33;
    s = 2'b01; tick();
    chk_regs("seq_01", 8'h33, 2'b01, 1'b1);

    // Asynchronous reset mid-stream, away from any rising edge.
    #1;
    rst = 1'b1; #1;
    chk_regs("async_rst", 8'h00, 2'b00, 1'b0);
    chk("out_in_rst", out, 8'h33);

    // Release with S=10, in2=01: pulse on first edge, gone on the next.
    s = 2'b10; in2 = 8'h01;
    rst = 1'b0;
    tick();
    chk_regs("post_rst_1", 8'h01, 2'b10, 1'b1);
    tick();
    chk_regs("post_rst_2", 8'h01, 2'b10, 1'b0);

    // S and the newly selected input change together before one edge.
    s = 2'b00; in0 = 8'hC3; in2 = 8'h7E;
    tick();
    chk_regs("simul_change", 8'hC3, 2'b00, 1'b1);
    chk("out_simul", out, 8'hC3);

    // Unknown select must not fall back to a source.
    clk_en = 1'b0;
    #10;
    s = 2'bxx; #10;
    if ($isunknown(s)) chk("sel_x", out, 8'hxx);
    else               chk("sel_x_2state", out, pick(s, in0, in1, in2, in3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
